// File: rtl/core_mgmt_axil_bridge.sv
// AXI4-Lite slave front end for the core-management register map: independent write and read FSMs with a read timeout.
// Optional build macro CORE_MGMT_ADDR_RANGE_CHECK_EN rejects addresses outside the 32-entry map with SLVERR.
module core_mgmt_axil_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              mg_wvalid,
  output logic [DATA_W-1:0] mg_wdata,
  output logic [ADDR_W-1:0] mg_waddr,
  output logic              mg_arvalid,
  output logic [ADDR_W-1:0] mg_raddr,
  input  logic              mg_rvalid,
  input  logic [DATA_W-1:0] mg_rdata
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ISSUE = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;

  localparam logic [7:0]        TMO      = 8'(RD_TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);
  localparam logic [1:0]        RESP_OK  = 2'b00;
  localparam logic [1:0]        RESP_ERR = 2'b10;
`ifdef CORE_MGMT_ADDR_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    return RANGE_EN && (|a[ADDR_W-1:5]);
  endfunction

  w_state_e          w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d, werr_q, werr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              s_awready_q, s_awready_d, s_wready_q, s_wready_d;
  logic              mg_wvalid_q, mg_wvalid_d, s_bvalid_q, s_bvalid_d;
  logic [1:0]        s_bresp_q, s_bresp_d;

  r_state_e          r_state_q, r_state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              s_arready_q, s_arready_d, mg_arvalid_q, mg_arvalid_d, s_rvalid_q, s_rvalid_d;

  // Write path next state; outputs are decoded from the next state so they are registered.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    werr_d    = werr_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_awvalid && s_awready_q) begin
          aw_held_d = 1'b1;
          waddr_d   = s_awaddr;
          werr_d    = addr_oob(s_awaddr);
        end else begin
          aw_held_d = aw_held_q;
        end
        if (s_wvalid && s_wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
        end else begin
          w_held_d = w_held_q;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_ISSUE;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_ISSUE: w_state_d = W_RESP;
      W_RESP: begin
        if (s_bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
    s_awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    s_wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    mg_wvalid_d = (w_state_d == W_ISSUE) && !werr_d;
    s_bvalid_d  = (w_state_d == W_RESP);
    s_bresp_d   = ((w_state_d == W_RESP) && werr_d) ? RESP_ERR : RESP_OK;
  end

  // Write path state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q   <= W_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      werr_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      s_awready_q <= 1'b0;
      s_wready_q  <= 1'b0;
      mg_wvalid_q <= 1'b0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= 2'b00;
    end else begin
      w_state_q   <= w_state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      werr_q      <= werr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      s_awready_q <= s_awready_d;
      s_wready_q  <= s_wready_d;
      mg_wvalid_q <= mg_wvalid_d;
      s_bvalid_q  <= s_bvalid_d;
      s_bresp_q   <= s_bresp_d;
    end
  end

  // Read path next state; out-of-range reads skip the map and complete with error data directly.
  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid && s_arready_q) begin
          raddr_d = s_araddr;
          cnt_d   = 8'd0;
          if (addr_oob(s_araddr)) begin
            r_state_d = R_RESP;
            rdata_d   = ERR_DATA;
            rresp_d   = RESP_ERR;
          end else begin
            r_state_d = R_WAIT;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (mg_rvalid) begin
          r_state_d = R_RESP;
          rdata_d   = mg_rdata;
          rresp_d   = RESP_OK;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO) begin
            r_state_d = R_RESP;
            rdata_d   = ERR_DATA;
            rresp_d   = RESP_ERR;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_RESP: begin
        if (s_rready) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_RESP;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    s_arready_d  = (r_state_d == R_IDLE);
    mg_arvalid_d = (r_state_d == R_WAIT);
    s_rvalid_d   = (r_state_d == R_RESP);
  end

  // Read path state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q    <= R_IDLE;
      cnt_q        <= 8'd0;
      raddr_q      <= '0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
      s_arready_q  <= 1'b0;
      mg_arvalid_q <= 1'b0;
      s_rvalid_q   <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      cnt_q        <= cnt_d;
      raddr_q      <= raddr_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      s_arready_q  <= s_arready_d;
      mg_arvalid_q <= mg_arvalid_d;
      s_rvalid_q   <= s_rvalid_d;
    end
  end

  assign s_awready  = s_awready_q;
  assign s_wready   = s_wready_q;
  assign s_bvalid   = s_bvalid_q;
  assign s_bresp    = s_bresp_q;
  assign mg_wvalid  = mg_wvalid_q;
  assign mg_waddr   = waddr_q;
  assign mg_wdata   = wdata_q;
  assign s_arready  = s_arready_q;
  assign mg_arvalid = mg_arvalid_q;
  assign mg_raddr   = raddr_q;
  assign s_rvalid   = s_rvalid_q;
  assign s_rdata    = rdata_q;
  assign s_rresp    = rresp_q;

endmodule

// File: tb/tb_core_mgmt_axil_bridge.sv
// Directed self-checking bench for core_mgmt_axil_bridge; build with CORE_MGMT_ADDR_RANGE_CHECK_EN to cover range rejection.
module tb_core_mgmt_axil_bridge;

  logic        clk, rst;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        mg_wvalid, mg_arvalid, mg_rvalid;
  logic [31:0] mg_wdata, mg_waddr, mg_raddr, mg_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int wpulse = 0;
  int p0;
  int n;

  core_mgmt_axil_bridge #(.ADDR_W(32), .DATA_W(32), .RD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .mg_wvalid(mg_wvalid), .mg_wdata(mg_wdata), .mg_waddr(mg_waddr),
    .mg_arvalid(mg_arvalid), .mg_raddr(mg_raddr),
    .mg_rvalid(mg_rvalid), .mg_rdata(mg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count map write strobes so extra or missing pulses are visible.
  always @(negedge clk) if (mg_wvalid) wpulse++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_w(input logic [31:0] a, input logic [31:0] d);
    s_awvalid = 1'b1; s_awaddr = a; s_wvalid = 1'b1; s_wdata = d;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_awvalid = 1'b0; s_awaddr = 32'h0; s_wvalid = 1'b0; s_wdata = 32'h0; s_bready = 1'b0;
    s_arvalid = 1'b0; s_araddr = 32'h0; s_rready = 1'b0;
    mg_rvalid = 1'b0; mg_rdata = 32'h0;
    #3 rst = 1'b0;
    repeat (3) tick();
    check_eq("rst_awready", s_awready, 1'b0);
    check_eq("rst_bvalid", s_bvalid, 1'b0);
    check_eq("rst_rvalid", s_rvalid, 1'b0);
    check_eq("rst_mg_wvalid", mg_wvalid, 1'b0);
    check_eq("rst_mg_arvalid", mg_arvalid, 1'b0);
    rst = 1'b1;
    tick();
    check_eq("idle_awready", s_awready, 1'b1);
    check_eq("idle_wready", s_wready, 1'b1);
    check_eq("idle_arready", s_arready, 1'b1);

    // Same-cycle AW and W.
    p0 = wpulse;
    aw_w(32'h10, 32'h5);
    check_eq("t1_mg_wvalid", mg_wvalid, 1'b1);
    check_eq("t1_waddr", mg_waddr, 32'h10);
    check_eq("t1_wdata", mg_wdata, 32'h5);
    check_eq("t1_awready_busy", s_awready, 1'b0);
    tick();
    check_eq("t1_mg_wvalid_drop", mg_wvalid, 1'b0);
    check_eq("t1_bvalid", s_bvalid, 1'b1);
    check_eq("t1_bresp", s_bresp, 2'b00);
    tick();
    check_eq("t1_bvalid_hold", s_bvalid, 1'b1);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check_eq("t1_bvalid_done", s_bvalid, 1'b0);
    check_eq("t1_awready_back", s_awready, 1'b1);
    check_eq("t1_pulses", wpulse - p0, 1);

    // W three cycles ahead of AW.
    p0 = wpulse;
    s_wvalid = 1'b1; s_wdata = 32'hA5;
    tick();
    s_wvalid = 1'b0;
    check_eq("t2_wready_drop", s_wready, 1'b0);
    check_eq("t2_awready", s_awready, 1'b1);
    tick();
    tick();
    check_eq("t2_no_early_strobe", mg_wvalid, 1'b0);
    s_awvalid = 1'b1; s_awaddr = 32'h8;
    tick();
    s_awvalid = 1'b0;
    check_eq("t2_mg_wvalid", mg_wvalid, 1'b1);
    check_eq("t2_waddr", mg_waddr, 32'h8);
    check_eq("t2_wdata", mg_wdata, 32'hA5);
    tick();
    check_eq("t2_bvalid", s_bvalid, 1'b1);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    tick();
    tick();
    check_eq("t2_pulses", wpulse - p0, 1);

    // Read with the map answering immediately.
    mg_rvalid = 1'b1; mg_rdata = 32'h1;
    s_arvalid = 1'b1; s_araddr = 32'h4;
    tick();
    s_arvalid = 1'b0;
    check_eq("t3_mg_arvalid", mg_arvalid, 1'b1);
    check_eq("t3_raddr", mg_raddr, 32'h4);
    check_eq("t3_rvalid_early", s_rvalid, 1'b0);
    tick();
    check_eq("t3_rvalid", s_rvalid, 1'b1);
    check_eq("t3_mg_arvalid_drop", mg_arvalid, 1'b0);
    mg_rdata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_rdata_stable", s_rdata, 32'h1);
      check_eq("t3_rvalid_stable", s_rvalid, 1'b1);
      tick();
    end
    check_eq("t3_rresp", s_rresp, 2'b00);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    mg_rvalid = 1'b0;
    check_eq("t3_rvalid_done", s_rvalid, 1'b0);
    check_eq("t3_arready_back", s_arready, 1'b1);

    // Read timeout with a silent map.
    s_arvalid = 1'b1; s_araddr = 32'hC;
    tick();
    s_arvalid = 1'b0;
    n = 0;
    while (mg_arvalid && n < 40) begin
      n++;
      tick();
    end
    check_eq("t4_arvalid_cycles", n, 16);
    check_eq("t4_rvalid", s_rvalid, 1'b1);
    check_eq("t4_rdata", s_rdata, 32'hDEADBEEF);
    check_eq("t4_rresp", s_rresp, 2'b10);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;

    // Reset while a B beat is pending.
    aw_w(32'h3, 32'h33);
    tick();
    check_eq("t5_bvalid_pre", s_bvalid, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("t5_bvalid_async", s_bvalid, 1'b0);
    tick();
    check_eq("t5_bvalid_in_rst", s_bvalid, 1'b0);
    rst = 1'b1;
    tick();
    check_eq("t5_bvalid_after", s_bvalid, 1'b0);
    check_eq("t5_awready", s_awready, 1'b1);
    p0 = wpulse;
    aw_w(32'h1C, 32'h99);
    check_eq("t5_mg_wvalid", mg_wvalid, 1'b1);
    check_eq("t5_waddr", mg_waddr, 32'h1C);
    tick();
    check_eq("t5_bvalid", s_bvalid, 1'b1);
    check_eq("t5_bresp", s_bresp, 2'b00);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check_eq("t5_pulses", wpulse - p0, 1);

    // Address outside the 32-entry map.
    aw_w(32'h40, 32'h12);
`ifdef CORE_MGMT_ADDR_RANGE_CHECK_EN
    check_eq("t6_mg_wvalid_sup", mg_wvalid, 1'b0);
    tick();
    check_eq("t6_bvalid", s_bvalid, 1'b1);
    check_eq("t6_bresp", s_bresp, 2'b10);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    s_arvalid = 1'b1; s_araddr = 32'h40;
    tick();
    s_arvalid = 1'b0;
    check_eq("t6_mg_arvalid_sup", mg_arvalid, 1'b0);
    check_eq("t6_rvalid", s_rvalid, 1'b1);
    check_eq("t6_rdata", s_rdata, 32'hDEADBEEF);
    check_eq("t6_rresp", s_rresp, 2'b10);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
`else
    check_eq("t6_mg_wvalid_fwd", mg_wvalid, 1'b1);
    check_eq("t6_waddr_fwd", mg_waddr, 32'h40);
    tick();
    check_eq("t6_bvalid", s_bvalid, 1'b1);
    check_eq("t6_bresp", s_bresp, 2'b00);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_mgmt_axil_bridge.md
Name:
core_mgmt_axil_bridge

Overview:
- AXI4-Lite slave that sits directly upstream of the core-management register map.
- Converts AXI-Lite write/read transactions into the map's simple strobes (write-valid/wdata/waddr, arvalid/raddr) and returns its rvalid/rdata as an AXI R beat.
- Decouples AW/W ordering, owns B/R response handshaking, and guards reads with a timeout so a powered-down map cannot hang the bus.

Parameters:
- ADDR_W, 32, width of AXI and map addresses.
- DATA_W, 32, width of data on both sides.
- RD_TIMEOUT, 16, cycles to wait for mg_rvalid before error completion; legal range 1..255; internal counter is 8 bits.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted, release synchronised externally).
s_awvalid  input  1  AXI write-address valid.
s_awready  output  1  AXI write-address ready.
s_awaddr  input  ADDR_W  AXI write address.
s_wvalid  input  1  AXI write-data valid.
s_wready  output  1  AXI write-data ready.
s_wdata  input  DATA_W  AXI write data (full-word only; strobes not supported).
s_bvalid  output  1  AXI write-response valid.
s_bready  input  1  AXI write-response ready.
s_bresp  output  2  AXI write response (00 OKAY, 10 SLVERR).
s_arvalid  input  1  AXI read-address valid.
s_arready  output  1  AXI read-address ready.
s_araddr  input  ADDR_W  AXI read address.
s_rvalid  output  1  AXI read-data valid.
s_rready  input  1  AXI read-data ready.
s_rdata  output  DATA_W  AXI read data.
s_rresp  output  2  AXI read response.
mg_wvalid  output  1  one-cycle write strobe to the register map.
mg_wdata  output  DATA_W  write data to the map.
mg_waddr  output  ADDR_W  write address to the map.
mg_arvalid  output  1  read request to the map, held until mg_rvalid or timeout.
mg_raddr  output  ADDR_W  read address to the map.
mg_rvalid  input  1  map read-data valid; may be high in the same cycle as mg_arvalid.
mg_rdata  input  DATA_W  map read data.

Behaviour:
- Reset (rst=0, async): all outputs 0, both FSMs idle, hold flags and timeout counter cleared. Reset mid-transaction drops it; no B or R beat is produced afterwards.
- Write FSM (W_IDLE, W_ISSUE, W_RESP), address/data capture:
  - s_awready = W_IDLE && !aw_held; s_wready = W_IDLE && !w_held.
  - AW and W are captured independently in either order, or in the same cycle.
- Write FSM transitions:
  - W_IDLE -> W_ISSUE on the cycle both are held (including same-cycle capture).
  - W_ISSUE: mg_wvalid=1 for exactly one cycle with the registered address/data; then W_RESP.
  - W_RESP: s_bvalid=1, s_bresp=00, held stable until s_bready; clears both hold flags; then W_IDLE. A new AW/W is accepted on the following cycle at the earliest.
- Read FSM (R_IDLE, R_WAIT, R_RESP):
  - R_IDLE: s_arready=1. On handshake, register the address and go to R_WAIT.
  - R_WAIT: mg_arvalid=1 with registered mg_raddr.
    - If mg_rvalid=1, capture mg_rdata with rresp=00 and go to R_RESP.
    - Otherwise increment the counter; when it reaches RD_TIMEOUT, set rdata=32'hDEAD_BEEF, rresp=10 and go to R_RESP.
  - R_RESP: s_rvalid=1 with data held stable until s_rready, then R_IDLE.
- Read latency with an immediate map response: s_rvalid is asserted 2 cycles after the AR handshake.
- Write and read FSMs run independently; mg_wvalid and mg_arvalid may be asserted in the same cycle.

Optional Feature:
- Macro CORE_MGMT_ADDR_RANGE_CHECK_EN.
- Defined: an address with any bit set at or above bit 5 (outside the 32-entry map) suppresses mg_wvalid (write) or mg_arvalid (read). Writes complete with bresp=10. Reads return 32'hDEAD_BEEF with rresp=10 one cycle after the AR handshake.
- Undefined: all addresses are forwarded unchanged.

Test Plan:
- AW(0x10) and W(0x5) presented in the same cycle -> mg_wvalid high for exactly 1 cycle with waddr=0x10, wdata=0x5; s_bvalid next cycle with bresp=00.
- W presented 3 cycles before AW -> s_wready drops after W capture; a single mg_wvalid pulse after AW arrives; no second strobe.
- AR(0x4) with mg_rvalid=1 and mg_rdata=0x1 combinationally -> s_rvalid 2 cycles after handshake with rdata=0x1, rresp=00; s_rready held low 5 cycles -> data stable throughout.
- AR with mg_rvalid held 0, RD_TIMEOUT=16 -> mg_arvalid high for 16 cycles, then rdata=0xDEADBEEF, rresp=10.
- rst pulsed low while in W_RESP with s_bready=0 -> s_bvalid=0 immediately and stays 0; next write completes normally.
- With CORE_MGMT_ADDR_RANGE_CHECK_EN, write to 0x40 -> no mg_wvalid, bresp=10.
